ps2_scan_receiver: RTL and testbench

- PS/2 device-to-host receiver in the pixelClk domain, directly upstream of the keyboard code mapper.
- Filters the asynchronous ps2Clk/ps2Data lines and deframes 11-bit PS/2 frames.
- Checks odd parity and the stop bit, handles the 0xF0 (break) and 0xE0 (extended) prefixes.
- Emits one qualified make/break scan-code event per key action.

---
 rtl/ps2_scan_receiver.sv | 185 ++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host scan-code receiver: conditions the raw PS/2 lines, deframes
// 11-bit frames, folds 0xF0/0xE0 prefixes into one qualified make/break event.
`timescale 1ns/1ps

module ps2_scan_receiver #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 5000
) (
  input  logic       pixelClk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       keyRelease,
  output logic       keyExt,
  output logic       codeValid,
  output logic       frameErr
);

  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TOW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic           filt_clk_q, filt_clk_d, filt_prev_q, filt_prev_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall_edge;
  state_t         state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           parity_q, parity_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           brk_q, brk_d, ext_q, ext_d;
  logic [7:0]     scan_q, scan_d;
  logic           rel_q, rel_d, kext_q, kext_d;
  logic           valid_q, valid_d, err_q, err_d;

  always_comb begin
    clk_s1_d    = ps2Clk;
    clk_s2_d    = clk_s1_q;
    dat_s1_d    = ps2Data;
    dat_s2_d    = dat_s1_q;
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = '0;
    filt_prev_d = filt_clk_q;
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    parity_d    = parity_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    scan_d      = scan_q;
    rel_d       = rel_q;
    kext_d      = kext_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end

    fall_edge = filt_prev_q & ~filt_clk_q;

    if ((state_q == S_IDLE) || fall_edge) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TOW'(1);
    end

    if (fall_edge) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          parity_d = dat_s2_q;
          state_d  = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (dat_s2_q && (^{shift_q, parity_q})) begin
            if (shift_q == BREAK_PREFIX) begin
              brk_d = 1'b1;
            end else if (shift_q == EXT_PREFIX) begin
              ext_d = 1'b1;
            end else begin
              scan_d  = shift_q;
              rel_d   = brk_q;
              kext_d  = ext_q;
              valid_d = 1'b1;
              brk_d   = 1'b0;
              ext_d   = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end
      endcase
    end else if ((state_q != S_IDLE) && (to_cnt_q == TOW'(TIMEOUT - 1))) begin
      // Stalled frame: abandon it and drop any pending prefix.
      state_d = S_IDLE;
      err_d   = 1'b1;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
    end
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_clk_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      scan_q      <= '0;
      rel_q       <= 1'b0;
      kext_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_clk_q  <= filt_clk_d;
      filt_prev_q <= filt_prev_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      scan_q      <= scan_d;
      rel_q       <= rel_d;
      kext_q      <= kext_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign scanCode   = scan_q;
  assign keyRelease = rel_q;
  assign keyExt     = kext_q;
  assign codeValid  = valid_q;
  assign frameErr   = err_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver: directed and random PS/2 frames, expected
// events queued from a byte-level protocol model, popped by an independent monitor.
`timescale 1ns/1ps

module tb_ps2_scan_receiver;

  logic       pixelClk = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2Clk   = 1'b1;
  logic       ps2Data  = 1'b1;
  logic [7:0] scanCode;
  logic       keyRelease, keyExt, codeValid, frameErr;

  ps2_scan_receiver #(.FILTER_LEN(4), .TIMEOUT(5000)) dut (
    .pixelClk  (pixelClk),
    .reset     (reset),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .scanCode  (scanCode),
    .keyRelease(keyRelease),
    .keyExt    (keyExt),
    .codeValid (codeValid),
    .frameErr  (frameErr)
  );

  always #20 pixelClk = ~pixelClk;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } ev_t;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_fall = 0;
  int         half = 40;
  logic       m_brk = 1'b0, m_ext = 1'b0;
  logic [7:0] m_code = 8'h00;
  logic       m_rel = 1'b0, m_xt = 1'b0;

  always @(posedge pixelClk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Byte-level protocol model: what the host should report for one whole frame.
  task automatic model_frame(input logic [7:0] b, input bit good);
    ev_t e;
    if (!good) begin
      e = '{err: 1'b1, code: m_code, rel: m_rel, ext: m_xt};
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      m_code = b;
      m_rel  = m_brk;
      m_xt   = m_ext;
      e = '{err: 1'b0, code: m_code, rel: m_rel, ext: m_xt};
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge pixelClk);
    ps2Data = b;
    repeat (half) @(negedge pixelClk);
    ps2Clk    = 1'b0;
    last_fall = cyc;
    repeat (half) @(negedge pixelClk);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_after);
    logic par;
    model_frame(b, !(bad_par || bad_stop));
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      ps2_bit(b[i]);
      if (i == glitch_after) begin
        repeat (half / 2) @(negedge pixelClk);
        ps2Clk = 1'b0;
        repeat (2) @(negedge pixelClk);
        ps2Clk = 1'b1;
      end
    end
    ps2_bit(par);
    ps2_bit(!bad_stop);
    ps2Data = 1'b1;
    repeat (100) @(negedge pixelClk);
  endtask

  // Monitor: every event the DUT presents must match the head of the queue.
  always @(negedge pixelClk) begin
    ev_t e;
    if (codeValid || frameErr) begin
      check("exclusive_pulses", int'(codeValid & frameErr), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("event_is_err", int'(frameErr), int'(e.err));
        check("scanCode", int'(scanCode), int'(e.code));
        check("keyRelease", int'(keyRelease), int'(e.rel));
        check("keyExt", int'(keyExt), int'(e.ext));
      end
    end
  end

  initial begin
    int  t0, d, r;
    bit  seen;
    logic [7:0] b;

    repeat (5) @(negedge pixelClk);
    reset = 1'b0;
    check("rst_scanCode", int'(scanCode), 0);
    check("rst_keyRelease", int'(keyRelease), 0);
    check("rst_keyExt", int'(keyExt), 0);
    check("rst_codeValid", int'(codeValid), 0);
    check("rst_frameErr", int'(frameErr), 0);
    repeat (20) @(negedge pixelClk);

    // Make code at a ~12 kHz PS/2 clock.
    half = 1042;
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    half = 40;

    // Break, plain make, extended break.
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    send_frame(8'hE0, 1'b0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    send_frame(8'h75, 1'b0, 1'b0, -1);

    // Parity and stop errors, including one after a pending break prefix.
    send_frame(8'h1C, 1'b1, 1'b0, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    send_frame(8'h33, 1'b1, 1'b0, -1);
    send_frame(8'h33, 1'b0, 1'b0, -1);

    // Timeout after start + 4 data bits, then recovery.
    model_frame(8'h00, 1'b0);
    b = 8'($urandom);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i]);
    ps2Data = 1'b1;
    t0 = last_fall;
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge pixelClk);
      if (frameErr) seen = 1'b1;
    end
    d = cyc - t0;
    check("timeout_seen", int'(seen), 1);
    n_cmp++;
    if (seen && (d < 5000 || d > 5020)) begin
      n_bad++;
      $display("FAIL timeout_latency: actual=%0d required=5000..5020", d);
    end
    while (cyc - t0 < 6000) @(negedge pixelClk);
    send_frame(8'h29, 1'b0, 1'b0, -1);

    // Clock glitch while high mid-frame must not shift an extra bit.
    send_frame(8'h1C, 1'b0, 1'b0, 3);

    // Reset after 5 bits: outputs clear, partial frame discarded silently.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2Data = 1'b1;
    repeat (10) @(negedge pixelClk);
    reset = 1'b1;
    @(negedge pixelClk);
    reset = 1'b0;
    m_code = 8'h00; m_rel = 1'b0; m_xt = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
    check("mid_rst_scanCode", int'(scanCode), 0);
    check("mid_rst_keyRelease", int'(keyRelease), 0);
    check("mid_rst_keyExt", int'(keyExt), 0);
    check("mid_rst_frameErr", int'(frameErr), 0);
    repeat (20) @(negedge pixelClk);
    send_frame(8'h5A, 1'b0, 1'b0, -1);

    // Random frames with prefixes and errors mixed in.
    for (int n = 0; n < 16; n++) begin
      half = int'($urandom_range(30, 60));
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      case (r)
        0, 1:    send_frame(8'hF0, 1'b0, 1'b0, -1);
        2:       send_frame(8'hE0, 1'b0, 1'b0, -1);
        3:       send_frame(b, 1'b1, 1'b0, -1);
        4:       send_frame(b, 1'b0, 1'b1, -1);
        default: send_frame(b, 1'b0, 1'b0, -1);
      endcase
    end

    repeat (200) @(negedge pixelClk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
